// File: rtl/axi_rr_arbiter.sv
// Two-master, one-slave AXI4 arbiter. Independent read and write FSMs each
// hold a grant for a whole burst and re-arbitrate round-robin (or fixed
// priority when RR_EN=0) in their idle state.
module axi_rr_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  // Master 0 read
  input  logic [31:0] i_axi_araddr0,
  input  logic        i_axi_arvalid0,
  input  logic [3:0]  i_axi_arid0,
  input  logic [7:0]  i_axi_arlen0,
  input  logic [2:0]  i_axi_arsize0,
  input  logic [1:0]  i_axi_arburst0,
  output logic        o_axi_arready0,
  output logic [31:0] o_axi_rdata0,
  output logic        o_axi_rvalid0,
  output logic [1:0]  o_axi_rresp0,
  output logic [3:0]  o_axi_rid0,
  output logic        o_axi_rlast0,
  input  logic        i_axi_rready0,
  // Master 1 read
  input  logic [31:0] i_axi_araddr1,
  input  logic        i_axi_arvalid1,
  input  logic [3:0]  i_axi_arid1,
  input  logic [7:0]  i_axi_arlen1,
  input  logic [2:0]  i_axi_arsize1,
  input  logic [1:0]  i_axi_arburst1,
  output logic        o_axi_arready1,
  output logic [31:0] o_axi_rdata1,
  output logic        o_axi_rvalid1,
  output logic [1:0]  o_axi_rresp1,
  output logic [3:0]  o_axi_rid1,
  output logic        o_axi_rlast1,
  input  logic        i_axi_rready1,
  // Master 0 write
  input  logic [31:0] i_axi_awaddr0,
  input  logic        i_axi_awvalid0,
  input  logic [3:0]  i_axi_awid0,
  input  logic [7:0]  i_axi_awlen0,
  input  logic [2:0]  i_axi_awsize0,
  input  logic [1:0]  i_axi_awburst0,
  input  logic [31:0] i_axi_wdata0,
  input  logic [3:0]  i_axi_wstrb0,
  input  logic        i_axi_wvalid0,
  input  logic        i_axi_wlast0,
  output logic        o_axi_awready0,
  output logic        o_axi_wready0,
  output logic [1:0]  o_axi_bresp0,
  output logic        o_axi_bvalid0,
  output logic [3:0]  o_axi_bid0,
  input  logic        i_axi_bready0,
  // Master 1 write
  input  logic [31:0] i_axi_awaddr1,
  input  logic        i_axi_awvalid1,
  input  logic [3:0]  i_axi_awid1,
  input  logic [7:0]  i_axi_awlen1,
  input  logic [2:0]  i_axi_awsize1,
  input  logic [1:0]  i_axi_awburst1,
  input  logic [31:0] i_axi_wdata1,
  input  logic [3:0]  i_axi_wstrb1,
  input  logic        i_axi_wvalid1,
  input  logic        i_axi_wlast1,
  output logic        o_axi_awready1,
  output logic        o_axi_wready1,
  output logic [1:0]  o_axi_bresp1,
  output logic        o_axi_bvalid1,
  output logic [3:0]  o_axi_bid1,
  input  logic        i_axi_bready1,
  // Slave side read
  output logic [31:0] o_axi_araddr,
  output logic        o_axi_arvalid,
  output logic [3:0]  o_axi_arid,
  output logic [7:0]  o_axi_arlen,
  output logic [2:0]  o_axi_arsize,
  output logic [1:0]  o_axi_arburst,
  input  logic        i_axi_arready,
  input  logic [31:0] i_axi_rdata,
  input  logic        i_axi_rvalid,
  input  logic [1:0]  i_axi_rresp,
  input  logic [3:0]  i_axi_rid,
  input  logic        i_axi_rlast,
  output logic        o_axi_rready,
  // Slave side write
  output logic [31:0] o_axi_awaddr,
  output logic        o_axi_awvalid,
  output logic [3:0]  o_axi_awid,
  output logic [7:0]  o_axi_awlen,
  output logic [2:0]  o_axi_awsize,
  output logic [1:0]  o_axi_awburst,
  input  logic        i_axi_awready,
  output logic [31:0] o_axi_wdata,
  output logic [3:0]  o_axi_wstrb,
  output logic        o_axi_wvalid,
  output logic        o_axi_wlast,
  input  logic        i_axi_wready,
  input  logic [1:0]  i_axi_bresp,
  input  logic        i_axi_bvalid,
  input  logic [3:0]  i_axi_bid,
  output logic        o_axi_bready,
  // Grant status
  output logic [1:0]  o_rd_grant,
  output logic [1:0]  o_wr_grant
);

  // State codes double as the one-hot grant encoding.
  localparam logic [1:0] R_IDLE = 2'b00;
  localparam logic [1:0] R_M0   = 2'b01;
  localparam logic [1:0] R_M1   = 2'b10;
  localparam logic [1:0] W_IDLE = 2'b00;
  localparam logic [1:0] W_M0   = 2'b01;
  localparam logic [1:0] W_M1   = 2'b10;

  logic [1:0] rd_state;
  logic [1:0] wr_state;
  logic       rd_last;
  logic       wr_last;
  logic       rd_done;
  logic       wr_done;
  logic       rd_pick0;
  logic       wr_pick0;

  // A burst ends only on the final read beat or on the write response.
  assign rd_done = i_axi_rvalid & o_axi_rready & i_axi_rlast;
  assign wr_done = i_axi_bvalid & o_axi_bready;

  // Master 0 wins when alone, on a tie with fixed priority, or when master 1
  // was granted last.
  assign rd_pick0 = i_axi_arvalid0 & (~i_axi_arvalid1 | ~RR_EN | rd_last);
  assign wr_pick0 = i_axi_awvalid0 & (~i_axi_awvalid1 | ~RR_EN | wr_last);

  // Read FSM and round-robin pointer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_state <= R_IDLE;
      rd_last  <= 1'b1;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_pick0) begin
            rd_state <= R_M0;
            rd_last  <= 1'b0;
          end else if (i_axi_arvalid1) begin
            rd_state <= R_M1;
            rd_last  <= 1'b1;
          end
        end
        R_M0, R_M1: if (rd_done) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM and round-robin pointer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_state <= W_IDLE;
      wr_last  <= 1'b1;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_pick0) begin
            wr_state <= W_M0;
            wr_last  <= 1'b0;
          end else if (i_axi_awvalid1) begin
            wr_state <= W_M1;
            wr_last  <= 1'b1;
          end
        end
        W_M0, W_M1: if (wr_done) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign o_rd_grant = rd_state;
  assign o_wr_grant = wr_state;

  // Read routing: owner's AR/rready go to the slave, R goes to the owner only.
  always_comb begin
    o_axi_araddr   = '0;
    o_axi_arvalid  = 1'b0;
    o_axi_arid     = '0;
    o_axi_arlen    = '0;
    o_axi_arsize   = '0;
    o_axi_arburst  = '0;
    o_axi_rready   = 1'b0;
    o_axi_arready0 = 1'b0;
    o_axi_rdata0   = '0;
    o_axi_rvalid0  = 1'b0;
    o_axi_rresp0   = '0;
    o_axi_rid0     = '0;
    o_axi_rlast0   = 1'b0;
    o_axi_arready1 = 1'b0;
    o_axi_rdata1   = '0;
    o_axi_rvalid1  = 1'b0;
    o_axi_rresp1   = '0;
    o_axi_rid1     = '0;
    o_axi_rlast1   = 1'b0;
    case (rd_state)
      R_M0: begin
        o_axi_araddr   = i_axi_araddr0;
        o_axi_arvalid  = i_axi_arvalid0;
        o_axi_arid     = i_axi_arid0;
        o_axi_arlen    = i_axi_arlen0;
        o_axi_arsize   = i_axi_arsize0;
        o_axi_arburst  = i_axi_arburst0;
        o_axi_rready   = i_axi_rready0;
        o_axi_arready0 = i_axi_arready;
        o_axi_rdata0   = i_axi_rdata;
        o_axi_rvalid0  = i_axi_rvalid;
        o_axi_rresp0   = i_axi_rresp;
        o_axi_rid0     = i_axi_rid;
        o_axi_rlast0   = i_axi_rlast;
      end
      R_M1: begin
        o_axi_araddr   = i_axi_araddr1;
        o_axi_arvalid  = i_axi_arvalid1;
        o_axi_arid     = i_axi_arid1;
        o_axi_arlen    = i_axi_arlen1;
        o_axi_arsize   = i_axi_arsize1;
        o_axi_arburst  = i_axi_arburst1;
        o_axi_rready   = i_axi_rready1;
        o_axi_arready1 = i_axi_arready;
        o_axi_rdata1   = i_axi_rdata;
        o_axi_rvalid1  = i_axi_rvalid;
        o_axi_rresp1   = i_axi_rresp;
        o_axi_rid1     = i_axi_rid;
        o_axi_rlast1   = i_axi_rlast;
      end
      default: ;
    endcase
  end

  // Write routing: owner's AW/W/bready go to the slave, B goes to the owner only.
  always_comb begin
    o_axi_awaddr   = '0;
    o_axi_awvalid  = 1'b0;
    o_axi_awid     = '0;
    o_axi_awlen    = '0;
    o_axi_awsize   = '0;
    o_axi_awburst  = '0;
    o_axi_wdata    = '0;
    o_axi_wstrb    = '0;
    o_axi_wvalid   = 1'b0;
    o_axi_wlast    = 1'b0;
    o_axi_bready   = 1'b0;
    o_axi_awready0 = 1'b0;
    o_axi_wready0  = 1'b0;
    o_axi_bresp0   = '0;
    o_axi_bvalid0  = 1'b0;
    o_axi_bid0     = '0;
    o_axi_awready1 = 1'b0;
    o_axi_wready1  = 1'b0;
    o_axi_bresp1   = '0;
    o_axi_bvalid1  = 1'b0;
    o_axi_bid1     = '0;
    case (wr_state)
      W_M0: begin
        o_axi_awaddr   = i_axi_awaddr0;
        o_axi_awvalid  = i_axi_awvalid0;
        o_axi_awid     = i_axi_awid0;
        o_axi_awlen    = i_axi_awlen0;
        o_axi_awsize   = i_axi_awsize0;
        o_axi_awburst  = i_axi_awburst0;
        o_axi_wdata    = i_axi_wdata0;
        o_axi_wstrb    = i_axi_wstrb0;
        o_axi_wvalid   = i_axi_wvalid0;
        o_axi_wlast    = i_axi_wlast0;
        o_axi_bready   = i_axi_bready0;
        o_axi_awready0 = i_axi_awready;
        o_axi_wready0  = i_axi_wready;
        o_axi_bresp0   = i_axi_bresp;
        o_axi_bvalid0  = i_axi_bvalid;
        o_axi_bid0     = i_axi_bid;
      end
      W_M1: begin
        o_axi_awaddr   = i_axi_awaddr1;
        o_axi_awvalid  = i_axi_awvalid1;
        o_axi_awid     = i_axi_awid1;
        o_axi_awlen    = i_axi_awlen1;
        o_axi_awsize   = i_axi_awsize1;
        o_axi_awburst  = i_axi_awburst1;
        o_axi_wdata    = i_axi_wdata1;
        o_axi_wstrb    = i_axi_wstrb1;
        o_axi_wvalid   = i_axi_wvalid1;
        o_axi_wlast    = i_axi_wlast1;
        o_axi_bready   = i_axi_bready1;
        o_axi_awready1 = i_axi_awready;
        o_axi_wready1  = i_axi_wready;
        o_axi_bresp1   = i_axi_bresp;
        o_axi_bvalid1  = i_axi_bvalid;
        o_axi_bid1     = i_axi_bid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: a round-robin instance plus a
// fixed-priority instance sharing the same stimulus.
module tb_axi_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Master-side inputs
  logic [31:0] araddr0, araddr1, awaddr0, awaddr1, wdata0, wdata1;
  logic        arvalid0, arvalid1, awvalid0, awvalid1, wvalid0, wvalid1, wlast0, wlast1;
  logic [3:0]  arid0, arid1, awid0, awid1, wstrb0, wstrb1;
  logic [7:0]  arlen0, arlen1, awlen0, awlen1;
  logic [2:0]  arsize0, arsize1, awsize0, awsize1;
  logic [1:0]  arburst0, arburst1, awburst0, awburst1;
  logic        rready0, rready1, bready0, bready1;
  // Slave-side inputs
  logic        s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_rid, s_bid;

  // Round-robin instance outputs
  logic        arready0, arready1, rvalid0, rvalid1, rlast0, rlast1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, rresp1, bresp0, bresp1;
  logic [3:0]  rid0, rid1, bid0, bid1;
  logic        awready0, awready1, wready0, wready1, bvalid0, bvalid1;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready;
  logic [3:0]  m_arid, m_awid, m_wstrb;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst;
  logic [1:0]  rd_grant, wr_grant;

  // Fixed-priority instance outputs
  logic        fx_arready0, fx_arready1, fx_rvalid0, fx_rvalid1, fx_rlast0, fx_rlast1;
  logic [31:0] fx_rdata0, fx_rdata1;
  logic [1:0]  fx_rresp0, fx_rresp1, fx_bresp0, fx_bresp1;
  logic [3:0]  fx_rid0, fx_rid1, fx_bid0, fx_bid1;
  logic        fx_awready0, fx_awready1, fx_wready0, fx_wready1, fx_bvalid0, fx_bvalid1;
  logic [31:0] fx_araddr, fx_awaddr, fx_wdata;
  logic        fx_arvalid, fx_rready, fx_awvalid, fx_wvalid, fx_wlast, fx_bready;
  logic [3:0]  fx_arid, fx_awid, fx_wstrb;
  logic [7:0]  fx_arlen, fx_awlen;
  logic [2:0]  fx_arsize, fx_awsize;
  logic [1:0]  fx_arburst, fx_awburst;
  logic [1:0]  fx_rd_grant, fx_wr_grant;

  axi_rr_arbiter #(.RR_EN(1'b1)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_axi_araddr0(araddr0), .i_axi_arvalid0(arvalid0), .i_axi_arid0(arid0), .i_axi_arlen0(arlen0),
    .i_axi_arsize0(arsize0), .i_axi_arburst0(arburst0), .o_axi_arready0(arready0),
    .o_axi_rdata0(rdata0), .o_axi_rvalid0(rvalid0), .o_axi_rresp0(rresp0), .o_axi_rid0(rid0),
    .o_axi_rlast0(rlast0), .i_axi_rready0(rready0),
    .i_axi_araddr1(araddr1), .i_axi_arvalid1(arvalid1), .i_axi_arid1(arid1), .i_axi_arlen1(arlen1),
    .i_axi_arsize1(arsize1), .i_axi_arburst1(arburst1), .o_axi_arready1(arready1),
    .o_axi_rdata1(rdata1), .o_axi_rvalid1(rvalid1), .o_axi_rresp1(rresp1), .o_axi_rid1(rid1),
    .o_axi_rlast1(rlast1), .i_axi_rready1(rready1),
    .i_axi_awaddr0(awaddr0), .i_axi_awvalid0(awvalid0), .i_axi_awid0(awid0), .i_axi_awlen0(awlen0),
    .i_axi_awsize0(awsize0), .i_axi_awburst0(awburst0), .i_axi_wdata0(wdata0), .i_axi_wstrb0(wstrb0),
    .i_axi_wvalid0(wvalid0), .i_axi_wlast0(wlast0), .o_axi_awready0(awready0), .o_axi_wready0(wready0),
    .o_axi_bresp0(bresp0), .o_axi_bvalid0(bvalid0), .o_axi_bid0(bid0), .i_axi_bready0(bready0),
    .i_axi_awaddr1(awaddr1), .i_axi_awvalid1(awvalid1), .i_axi_awid1(awid1), .i_axi_awlen1(awlen1),
    .i_axi_awsize1(awsize1), .i_axi_awburst1(awburst1), .i_axi_wdata1(wdata1), .i_axi_wstrb1(wstrb1),
    .i_axi_wvalid1(wvalid1), .i_axi_wlast1(wlast1), .o_axi_awready1(awready1), .o_axi_wready1(wready1),
    .o_axi_bresp1(bresp1), .o_axi_bvalid1(bvalid1), .o_axi_bid1(bid1), .i_axi_bready1(bready1),
    .o_axi_araddr(m_araddr), .o_axi_arvalid(m_arvalid), .o_axi_arid(m_arid), .o_axi_arlen(m_arlen),
    .o_axi_arsize(m_arsize), .o_axi_arburst(m_arburst), .i_axi_arready(s_arready),
    .i_axi_rdata(s_rdata), .i_axi_rvalid(s_rvalid), .i_axi_rresp(s_rresp), .i_axi_rid(s_rid),
    .i_axi_rlast(s_rlast), .o_axi_rready(m_rready),
    .o_axi_awaddr(m_awaddr), .o_axi_awvalid(m_awvalid), .o_axi_awid(m_awid), .o_axi_awlen(m_awlen),
    .o_axi_awsize(m_awsize), .o_axi_awburst(m_awburst), .i_axi_awready(s_awready),
    .o_axi_wdata(m_wdata), .o_axi_wstrb(m_wstrb), .o_axi_wvalid(m_wvalid), .o_axi_wlast(m_wlast),
    .i_axi_wready(s_wready), .i_axi_bresp(s_bresp), .i_axi_bvalid(s_bvalid), .i_axi_bid(s_bid),
    .o_axi_bready(m_bready), .o_rd_grant(rd_grant), .o_wr_grant(wr_grant)
  );

  axi_rr_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .i_clock(clk), .i_reset(rst),
    .i_axi_araddr0(araddr0), .i_axi_arvalid0(arvalid0), .i_axi_arid0(arid0), .i_axi_arlen0(arlen0),
    .i_axi_arsize0(arsize0), .i_axi_arburst0(arburst0), .o_axi_arready0(fx_arready0),
    .o_axi_rdata0(fx_rdata0), .o_axi_rvalid0(fx_rvalid0), .o_axi_rresp0(fx_rresp0), .o_axi_rid0(fx_rid0),
    .o_axi_rlast0(fx_rlast0), .i_axi_rready0(rready0),
    .i_axi_araddr1(araddr1), .i_axi_arvalid1(arvalid1), .i_axi_arid1(arid1), .i_axi_arlen1(arlen1),
    .i_axi_arsize1(arsize1), .i_axi_arburst1(arburst1), .o_axi_arready1(fx_arready1),
    .o_axi_rdata1(fx_rdata1), .o_axi_rvalid1(fx_rvalid1), .o_axi_rresp1(fx_rresp1), .o_axi_rid1(fx_rid1),
    .o_axi_rlast1(fx_rlast1), .i_axi_rready1(rready1),
    .i_axi_awaddr0(awaddr0), .i_axi_awvalid0(awvalid0), .i_axi_awid0(awid0), .i_axi_awlen0(awlen0),
    .i_axi_awsize0(awsize0), .i_axi_awburst0(awburst0), .i_axi_wdata0(wdata0), .i_axi_wstrb0(wstrb0),
    .i_axi_wvalid0(wvalid0), .i_axi_wlast0(wlast0), .o_axi_awready0(fx_awready0), .o_axi_wready0(fx_wready0),
    .o_axi_bresp0(fx_bresp0), .o_axi_bvalid0(fx_bvalid0), .o_axi_bid0(fx_bid0), .i_axi_bready0(bready0),
    .i_axi_awaddr1(awaddr1), .i_axi_awvalid1(awvalid1), .i_axi_awid1(awid1), .i_axi_awlen1(awlen1),
    .i_axi_awsize1(awsize1), .i_axi_awburst1(awburst1), .i_axi_wdata1(wdata1), .i_axi_wstrb1(wstrb1),
    .i_axi_wvalid1(wvalid1), .i_axi_wlast1(wlast1), .o_axi_awready1(fx_awready1), .o_axi_wready1(fx_wready1),
    .o_axi_bresp1(fx_bresp1), .o_axi_bvalid1(fx_bvalid1), .o_axi_bid1(fx_bid1), .i_axi_bready1(bready1),
    .o_axi_araddr(fx_araddr), .o_axi_arvalid(fx_arvalid), .o_axi_arid(fx_arid), .o_axi_arlen(fx_arlen),
    .o_axi_arsize(fx_arsize), .o_axi_arburst(fx_arburst), .i_axi_arready(s_arready),
    .i_axi_rdata(s_rdata), .i_axi_rvalid(s_rvalid), .i_axi_rresp(s_rresp), .i_axi_rid(s_rid),
    .i_axi_rlast(s_rlast), .o_axi_rready(fx_rready),
    .o_axi_awaddr(fx_awaddr), .o_axi_awvalid(fx_awvalid), .o_axi_awid(fx_awid), .o_axi_awlen(fx_awlen),
    .o_axi_awsize(fx_awsize), .o_axi_awburst(fx_awburst), .i_axi_awready(s_awready),
    .o_axi_wdata(fx_wdata), .o_axi_wstrb(fx_wstrb), .o_axi_wvalid(fx_wvalid), .o_axi_wlast(fx_wlast),
    .i_axi_wready(s_wready), .i_axi_bresp(s_bresp), .i_axi_bvalid(s_bvalid), .i_axi_bid(s_bid),
    .o_axi_bready(fx_bready), .o_rd_grant(fx_rd_grant), .o_wr_grant(fx_wr_grant)
  );

  // OR of every output of the round-robin instance; must be 0 when both FSMs idle.
  logic any_out;
  assign any_out = |{arready0, arready1, rvalid0, rvalid1, rlast0, rlast1, rdata0, rdata1,
                     rresp0, rresp1, bresp0, bresp1, rid0, rid1, bid0, bid1,
                     awready0, awready1, wready0, wready1, bvalid0, bvalid1,
                     m_araddr, m_awaddr, m_wdata, m_arvalid, m_rready, m_awvalid, m_wvalid,
                     m_wlast, m_bready, m_arid, m_awid, m_wstrb, m_arlen, m_awlen,
                     m_arsize, m_awsize, m_arburst, m_awburst, rd_grant, wr_grant};

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    araddr0 = '0; araddr1 = '0; awaddr0 = '0; awaddr1 = '0; wdata0 = '0; wdata1 = '0;
    arvalid0 = 0; arvalid1 = 0; awvalid0 = 0; awvalid1 = 0; wvalid0 = 0; wvalid1 = 0;
    wlast0 = 0; wlast1 = 0; arid0 = '0; arid1 = '0; awid0 = '0; awid1 = '0;
    wstrb0 = '0; wstrb1 = '0; arlen0 = '0; arlen1 = '0; awlen0 = '0; awlen1 = '0;
    arsize0 = 3'd2; arsize1 = 3'd2; awsize0 = 3'd2; awsize1 = 3'd2;
    arburst0 = 2'd1; arburst1 = 2'd1; awburst0 = 2'd1; awburst1 = 2'd1;
    rready0 = 0; rready1 = 0; bready0 = 0; bready1 = 0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
    s_rdata = '0; s_rresp = '0; s_bresp = '0; s_rid = '0; s_bid = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    // Stray responses during reset must not leak to either master.
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'hCAFE0000; s_bvalid = 1; s_bresp = 2'd2;
    step(); step();
    #1;
    total_cnt++; if (rd_grant !== 2'b00) $display("FAIL reset_rd_grant: got %b want 00", rd_grant); else pass_cnt++;
    total_cnt++; if (wr_grant !== 2'b00) $display("FAIL reset_wr_grant: got %b want 00", wr_grant); else pass_cnt++;
    total_cnt++; if (any_out !== 1'b0) $display("FAIL reset_outputs: got any_out=%b want 0", any_out); else pass_cnt++;
    total_cnt++; if (fx_rd_grant !== 2'b00) $display("FAIL reset_fx_grant: got %b want 00", fx_rd_grant); else pass_cnt++;
    rst = 0;
    step();
    #1;
    total_cnt++; if ((rvalid0 | rvalid1 | bvalid0 | bvalid1) !== 1'b0) $display("FAIL idle_resp_blocked: got %b want 0", rvalid0 | rvalid1 | bvalid0 | bvalid1); else pass_cnt++;
    clear_inputs();
    step();
  endtask

  task automatic test_read_tie();
    araddr0 = 32'h1000; araddr1 = 32'h2000; arvalid0 = 1; arvalid1 = 1;
    rready0 = 1; rready1 = 1;
    #1;
    total_cnt++; if (rd_grant !== 2'b00) $display("FAIL tie_latency: got %b want 00", rd_grant); else pass_cnt++;
    step();
    #1;
    total_cnt++; if (rd_grant !== 2'b01) $display("FAIL tie_first_grant: got %b want 01", rd_grant); else pass_cnt++;
    total_cnt++; if (m_araddr !== 32'h1000) $display("FAIL tie_araddr0: got %h want 00001000", m_araddr); else pass_cnt++;
    s_arready = 1;
    #1;
    total_cnt++; if ({arready1, arready0} !== 2'b01) $display("FAIL tie_arready: got %b want 01", {arready1, arready0}); else pass_cnt++;
    step();
    arvalid0 = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'h11111111;
    #1;
    total_cnt++; if (rdata0 !== 32'h11111111) $display("FAIL tie_rdata0: got %h want 11111111", rdata0); else pass_cnt++;
    total_cnt++; if (rvalid1 !== 1'b0) $display("FAIL tie_rvalid1_blocked: got %b want 0", rvalid1); else pass_cnt++;
    step();
    s_rvalid = 0; s_rlast = 0;
    #1;
    total_cnt++; if (rd_grant !== 2'b00) $display("FAIL tie_idle_gap: got %b want 00", rd_grant); else pass_cnt++;
    step();
    #1;
    total_cnt++; if (rd_grant !== 2'b10) $display("FAIL tie_second_grant: got %b want 10", rd_grant); else pass_cnt++;
    total_cnt++; if (m_araddr !== 32'h2000) $display("FAIL tie_araddr1: got %h want 00002000", m_araddr); else pass_cnt++;
    s_arready = 1;
    step();
    arvalid1 = 0; s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'h22222222;
    #1;
    total_cnt++; if (rdata1 !== 32'h22222222) $display("FAIL tie_rdata1: got %h want 22222222", rdata1); else pass_cnt++;
    total_cnt++; if (rvalid0 !== 1'b0) $display("FAIL tie_rvalid0_blocked: got %b want 0", rvalid0); else pass_cnt++;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_fairness();
    int n = 0;
    int cnt0 = 0;
    int fx_cnt0 = 0;
    int owner;
    rst = 1;
    step();
    rst = 0;
    arvalid0 = 1; arvalid1 = 1; rready0 = 1; rready1 = 1;
    s_arready = 1; s_rvalid = 1; s_rlast = 1;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      #1;
      if (rd_grant !== 2'b00) begin
        owner = (rd_grant == 2'b10) ? 1 : 0;
        total_cnt++; if (owner != (n % 2)) $display("FAIL rr_owner_%0d: got %0d want %0d", n, owner, n % 2); else pass_cnt++;
        if (owner == 0) cnt0++;
        if (fx_rd_grant == 2'b01) fx_cnt0++;
        n++;
      end
      step();
    end
    total_cnt++; if (n != 8) $display("FAIL rr_grant_count: got %0d want 8", n); else pass_cnt++;
    total_cnt++; if (cnt0 != 4) $display("FAIL rr_m0_share: got %0d want 4", cnt0); else pass_cnt++;
    total_cnt++; if (fx_cnt0 != 8) $display("FAIL fixed_m0_share: got %0d want 8", fx_cnt0); else pass_cnt++;
    clear_inputs();
    step();
  endtask

  task automatic test_burst_hold();
    araddr1 = 32'h3000; arlen1 = 8'd3; arvalid1 = 1; rready0 = 1; rready1 = 1;
    step();
    #1;
    total_cnt++; if (rd_grant !== 2'b10) $display("FAIL burst_grant: got %b want 10", rd_grant); else pass_cnt++;
    total_cnt++; if (m_arlen !== 8'd3) $display("FAIL burst_arlen: got %0d want 3", m_arlen); else pass_cnt++;
    s_arready = 1;
    step();
    arvalid1 = 0; s_arready = 0;
    for (int b = 1; b <= 4; b++) begin
      s_rvalid = 1; s_rlast = (b == 4); s_rdata = b;
      if (b == 1) begin araddr0 = 32'h4000; arvalid0 = 1; end
      #1;
      total_cnt++; if (rd_grant !== 2'b10) $display("FAIL burst_hold_beat%0d: got %b want 10", b, rd_grant); else pass_cnt++;
      total_cnt++; if (rvalid0 !== 1'b0) $display("FAIL burst_rvalid0_beat%0d: got %b want 0", b, rvalid0); else pass_cnt++;
      total_cnt++; if (rdata1 !== 32'(b)) $display("FAIL burst_rdata_beat%0d: got %h want %h", b, rdata1, 32'(b)); else pass_cnt++;
      step();
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    total_cnt++; if (rd_grant !== 2'b00) $display("FAIL burst_release: got %b want 00", rd_grant); else pass_cnt++;
    step();
    #1;
    total_cnt++; if (rd_grant !== 2'b01) $display("FAIL burst_next_owner: got %b want 01", rd_grant); else pass_cnt++;
    total_cnt++; if (m_araddr !== 32'h4000) $display("FAIL burst_next_araddr: got %h want 00004000", m_araddr); else pass_cnt++;
    s_arready = 1; s_rvalid = 1; s_rlast = 1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_write_tie();
    awaddr0 = 32'h5000; awaddr1 = 32'h6000; awvalid0 = 1; awvalid1 = 1;
    wdata0 = 32'hA; wdata1 = 32'hB; wstrb0 = 4'hF; wstrb1 = 4'hF;
    wvalid0 = 1; wvalid1 = 1; wlast0 = 1; wlast1 = 1; bready0 = 0; bready1 = 1;
    #1;
    total_cnt++; if (wr_grant !== 2'b00) $display("FAIL wtie_latency: got %b want 00", wr_grant); else pass_cnt++;
    step();
    #1;
    total_cnt++; if (wr_grant !== 2'b01) $display("FAIL wtie_first_grant: got %b want 01", wr_grant); else pass_cnt++;
    total_cnt++; if (m_awaddr !== 32'h5000) $display("FAIL wtie_awaddr0: got %h want 00005000", m_awaddr); else pass_cnt++;
    s_awready = 1; s_wready = 1;
    #1;
    total_cnt++; if ({awready1, wready0, awready0} !== 3'b011) $display("FAIL wtie_readies: got %b want 011", {awready1, wready0, awready0}); else pass_cnt++;
    total_cnt++; if (m_wdata !== 32'hA) $display("FAIL wtie_wdata0: got %h want 0000000a", m_wdata); else pass_cnt++;
    step();
    awvalid0 = 0; wvalid0 = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++; if (wr_grant !== 2'b01) $display("FAIL wtie_hold_%0d: got %b want 01", k, wr_grant); else pass_cnt++;
      total_cnt++; if ({m_bready, bvalid0} !== 2'b01) $display("FAIL wtie_bstall_%0d: got %b want 01", k, {m_bready, bvalid0}); else pass_cnt++;
      step();
    end
    bready0 = 1;
    #1;
    total_cnt++; if (m_bready !== 1'b1) $display("FAIL wtie_bready: got %b want 1", m_bready); else pass_cnt++;
    step();
    s_bvalid = 0;
    #1;
    total_cnt++; if (wr_grant !== 2'b00) $display("FAIL wtie_release: got %b want 00", wr_grant); else pass_cnt++;
    step();
    #1;
    total_cnt++; if (wr_grant !== 2'b10) $display("FAIL wtie_second_grant: got %b want 10", wr_grant); else pass_cnt++;
    total_cnt++; if (m_awaddr !== 32'h6000) $display("FAIL wtie_awaddr1: got %h want 00006000", m_awaddr); else pass_cnt++;
    s_awready = 1; s_wready = 1; s_bvalid = 1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_concurrent();
    araddr0 = 32'h8000_0000; arvalid0 = 1; rready0 = 1;
    awaddr1 = 32'h8000_0100; awid1 = 4'h5; awvalid1 = 1; wdata1 = 32'hDEADBEEF; wstrb1 = 4'hF;
    wvalid1 = 1; wlast1 = 1; bready1 = 1;
    step();
    #1;
    total_cnt++; if ({rd_grant, wr_grant} !== 4'b0110) $display("FAIL conc_grants: got %b want 0110", {rd_grant, wr_grant}); else pass_cnt++;
    total_cnt++; if (m_araddr !== 32'h8000_0000) $display("FAIL conc_araddr: got %h want 80000000", m_araddr); else pass_cnt++;
    total_cnt++; if (m_awaddr !== 32'h8000_0100) $display("FAIL conc_awaddr: got %h want 80000100", m_awaddr); else pass_cnt++;
    total_cnt++; if ({m_wdata, m_wstrb, m_awid} !== {32'hDEADBEEF, 4'hF, 4'h5}) $display("FAIL conc_wfields: got %h/%h/%h want deadbeef/f/5", m_wdata, m_wstrb, m_awid); else pass_cnt++;
    s_arready = 1; s_awready = 1; s_wready = 1;
    #1;
    total_cnt++; if ({arready0, awready1, wready1, awready0, arready1} !== 5'b11100) $display("FAIL conc_readies: got %b want 11100", {arready0, awready1, wready1, awready0, arready1}); else pass_cnt++;
    step();
    arvalid0 = 0; awvalid1 = 0; wvalid1 = 0; s_arready = 0; s_awready = 0; s_wready = 0;
    s_rvalid = 1; s_rlast = 1; s_rresp = 2'd0; s_rdata = 32'h12345678; s_bvalid = 1; s_bresp = 2'd0; s_bid = 4'h5;
    #1;
    total_cnt++; if ({rvalid0, rresp0, rvalid1} !== 4'b1000) $display("FAIL conc_rresp: got %b want 1000", {rvalid0, rresp0, rvalid1}); else pass_cnt++;
    total_cnt++; if ({bvalid1, bresp1, bid1, bvalid0} !== 8'b1000_1010) $display("FAIL conc_bresp: got %b want 10001010", {bvalid1, bresp1, bid1, bvalid0}); else pass_cnt++;
    step();
    clear_inputs();
    #1;
    total_cnt++; if ({rd_grant, wr_grant} !== 4'b0000) $display("FAIL conc_release: got %b want 0000", {rd_grant, wr_grant}); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_burst();
    araddr0 = 32'h9000; arlen0 = 8'd7; arvalid0 = 1; rready0 = 1;
    step();
    #1;
    total_cnt++; if (rd_grant !== 2'b01) $display("FAIL rmb_grant: got %b want 01", rd_grant); else pass_cnt++;
    s_arready = 1;
    step();
    arvalid0 = 0; s_arready = 0; s_rvalid = 1; s_rlast = 0; s_rdata = 32'h1;
    step();
    s_rdata = 32'h2; rst = 1;
    step();
    #1;
    total_cnt++; if ({rd_grant, wr_grant} !== 4'b0000) $display("FAIL rmb_grants: got %b want 0000", {rd_grant, wr_grant}); else pass_cnt++;
    total_cnt++; if (any_out !== 1'b0) $display("FAIL rmb_outputs: got any_out=%b want 0", any_out); else pass_cnt++;
    rst = 0; s_rvalid = 0; araddr1 = 32'hA000; arvalid1 = 1; rready1 = 1;
    #1;
    total_cnt++; if (rd_grant !== 2'b00) $display("FAIL rmb_idle: got %b want 00", rd_grant); else pass_cnt++;
    step();
    #1;
    total_cnt++; if (rd_grant !== 2'b10) $display("FAIL rmb_regrant: got %b want 10", rd_grant); else pass_cnt++;
    total_cnt++; if (m_araddr !== 32'hA000) $display("FAIL rmb_araddr: got %h want 0000a000", m_araddr); else pass_cnt++;
    s_arready = 1; s_rvalid = 1; s_rlast = 1;
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_read_tie();
    test_fairness();
    test_burst_hold();
    test_write_tie();
    test_concurrent();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_rr_arbiter.md
# axi_rr_arbiter

Two-master, one-slave AXI4 arbiter with independent round-robin read and write arbitration. Master 0 is the instruction-fetch port and master 1 is the load/store port; both have full read and write channels. The single slave side feeds the SoC crossbar. A grant is held for a whole burst and released only on the final response handshake (`rlast` for reads, B handshake for writes), so multi-beat bursts are never interleaved.

## Interface
- `RR_EN`, default 1: 1 = round-robin on a read or write tie; 0 = fixed priority, master 0 always wins a tie.
- `i_clock` input 1: single clock; every register updates on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_axi_ar{addr,valid,id,len,size,burst}{0,1}` input 32/1/4/8/3/2: AR requests from master 0 and master 1.
- `o_axi_arready{0,1}` output 1: AR ready back to each master.
- `o_axi_r{data,valid,resp,id,last}{0,1}` output 32/1/2/4/1: R beats returned to each master.
- `i_axi_rready{0,1}` input 1: R ready from each master.
- `i_axi_aw{addr,valid,id,len,size,burst}{0,1}` input 32/1/4/8/3/2: AW requests from each master.
- `i_axi_w{data,strb,valid,last}{0,1}` input 32/4/1/1: W beats from each master.
- `o_axi_awready{0,1}`, `o_axi_wready{0,1}` output 1: AW and W ready back to each master.
- `o_axi_b{resp,valid,id}{0,1}` output 2/1/4: B response to each master.
- `i_axi_bready{0,1}` input 1: B ready from each master.
- `o_axi_ar*`, `o_axi_rready`, `o_axi_aw*`, `o_axi_w*`, `o_axi_bready` output: slave-side request signals, same widths as above.
- `i_axi_arready`, `i_axi_r*`, `i_axi_awready`, `i_axi_wready`, `i_axi_b*` input: slave-side responses.
- `o_rd_grant` output 2: one-hot read owner; bit 0 = master 0, bit 1 = master 1; 00 = idle.
- `o_wr_grant` output 2: one-hot write owner, same encoding.

## Operation
- **Read FSM states:** R_IDLE, R_M0, R_M1.
- **Write FSM states:** W_IDLE, W_M0, W_M1.
- The two FSMs are fully independent. A read by one master and a write by the other may be in flight at the same time.
- **Read grant in R_IDLE:**
  - Only `arvalid0` high → R_M0.
  - Only `arvalid1` high → R_M1.
  - Both high → the master other than `rd_last` wins, where `rd_last` is the master that was granted most recently.
  - `RR_EN`=0 → master 0 wins every tie.
- **Write grant in W_IDLE:** same rule, using `awvalid0/1` and `wr_last`.
- `rd_last` and `wr_last` reset to 1, so master 0 wins the first tie after reset. Each pointer updates on the cycle its FSM grants.
- **Read release:** R_Mx → R_IDLE on `i_axi_rvalid & o_axi_rready & i_axi_rlast`. A non-last beat never releases the grant.
- **Write release:** W_Mx → W_IDLE on `i_axi_bvalid & o_axi_bready`.
- **Routing:**
  - In a granted state, all request signals of the owner are passed combinationally to the slave side, and the slave responses are passed combinationally to the owner only.
  - The non-owner sees every response output at 0, including `arready`, `awready`, `wready`, `rvalid` and `bvalid`. It stalls with its request held.
  - In an idle state, every slave-side output is 0.
- **Protocol error:** an R or B response arriving while its FSM is idle is not forwarded to either master. `o_axi_rready`/`o_axi_bready` are 0 in idle, so the response is simply not accepted.
- The block does not alter AXI fields: id, len, size, burst and strb pass through unchanged.

## Timing
- **Reset values:** read FSM = R_IDLE; write FSM = W_IDLE; `rd_last` = `wr_last` = 1; `o_rd_grant` = `o_wr_grant` = 00; every other output = 0.
- **Grant latency:** a master raising `arvalid` in cycle N (with the FSM idle) is granted at the edge ending N. It sees `o_axi_arvalid` forwarded in N+1, and AR can complete in N+1 at the earliest.
- **Back-to-back:** after a release edge there is exactly one idle cycle before the next grant can take effect. Minimum gap between consecutive bursts is 1 cycle.
- **Simultaneous events:** a release and a new `valid` in the same cycle are handled as release first; re-arbitration happens in the following idle cycle.
- **Reset mid-burst:** returns to idle immediately; any partially transferred burst is abandoned.
- `o_rd_grant`/`o_wr_grant` are registered, decoded directly from FSM state.

## Test plan
- **Read tie after reset:** `arvalid0` = `arvalid1` = 1 at cycle 2, `arlen` = 0 on both → master 0 gets `o_rd_grant` = 01 and its data 0x11111111. Master 1 is granted only after the `rlast` handshake plus one idle cycle, and gets 0x22222222.
- **Round-robin fairness:** both masters continuously request single-beat reads for 8 transactions → owners alternate 0,1,0,1…, 4 grants each. With `RR_EN`=0, all 8 go to master 0.
- **Burst hold:** master 1 reads with `arlen` = 3 while master 0 requests at beat 1 → grant stays 10 through 4 beats. `o_axi_rvalid0` stays 0 throughout, and master 0 is granted after beat 4 with `rlast` = 1.
- **Concurrent read/write:** master 0 reads 0x8000_0000 while master 1 writes 0xDEADBEEF with strb 0xF to 0x8000_0100 → `o_rd_grant` = 01 and `o_wr_grant` = 10 at the same time; both complete with resp = 0.
- **Write tie and B release:** `awvalid` and `wvalid` asserted on both masters → master 0 is granted first. The slave holds `bvalid` for 3 cycles with `bready0` = 0 → the grant is held until `bready0` = 1, then master 1 is granted.
- **Reset mid-burst:** `i_reset` pulsed on beat 2 of an `arlen` = 7 burst → next cycle both grants are 00 and all outputs are 0. A new request is granted normally after reset is deasserted.
